tc_irq_ctrl: RTL and testbench
==============================

Name: tc_irq_ctrl

Overview:
- Interrupt controller directly downstream of the timer/counter register block.
- Captures timer interrupt request lines (overflow, compare A, compare B, spare) into pending flags and masks them with per-source enables and a global enable.
- Arbitrates by fixed priority and presents one vectored request to the CPU core with a req/ack handshake.
- Software reaches its three registers over the same 8-bit addr/wdata/rdata/read/write bus used by the timer block.

Parameters:
- NSRC, 4, number of interrupt sources (1..8); index 0 is highest priority.
- VEC_BASE, 8'h0B, vector number issued for source 0; source i issues VEC_BASE+i.
- ADDR_PEND, 8'h3B, pending-flag register address.
- ADDR_EN, 8'h3D, per-source enable register address.
- ADDR_CTRL, 8'h3F, control register address; bit0 = GIE.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- src_irq  input  NSRC  interrupt request lines from the timer block.
- addr  input  8  register address.
- wdata  input  8  write data.
- write  input  1  write strobe, one cycle per access.
- read  input  1  read strobe, one cycle per access.
- rdata  output  8  registered read data.
- irq_req  output  1  request to the CPU.
- irq_vec  output  8  vector number; valid while irq_req=1.
- irq_ack  input  1  CPU acknowledge, single-cycle pulse.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. On rst: PEND=0, EN=0, GIE=0, state=IDLE, irq_req=0, irq_vec=0, rdata=0.
- PEND[i] set: set every cycle src_irq[i]=1 (level mode, see Optional Feature).
- PEND[i] clear: write of 1 to bit i at ADDR_PEND (write-1-to-clear; writing 0 has no effect), or irq_ack for the committed source.
- Set and clear in the same cycle: set wins and PEND[i] stays 1.
- EN and CTRL are plain read/write registers. Bits at or above NSRC in PEND/EN, and CTRL bits 7:1, write-ignore and read 0.
- Reads: rdata is updated on the clk edge where read=1 and holds its value otherwise. Unmapped address returns 8'h00. If read and write target the same register in the same cycle, rdata returns the pre-write value.
- State IDLE: when GIE=1 and (PEND & EN)!=0, latch the lowest set index into win, go to ARB.
- State ARB (1 cycle): drive irq_vec = VEC_BASE+win and irq_req=1, go to REQ.
- State REQ: irq_req and irq_vec stay stable until irq_ack=1. On ack: clear PEND[win], clear GIE, drop irq_req on the next edge, go to IDLE.
- Latency: src_irq high in cycle N -> PEND set at edge N+1 -> ARB at N+2 -> irq_req=1 from edge N+3.
- Commit rule: once in ARB/REQ the vector is committed. Clearing EN, PEND or GIE by software does not withdraw irq_req. Ack still clears PEND[win] and GIE.
- Stray ack: irq_ack outside REQ is ignored (no flag or GIE change).
- Nesting: none. Software re-enables by writing GIE=1 (the reti equivalent). Further pending sources then arbitrate from IDLE.
- irq_vec is left unchanged after irq_req falls. Arithmetic is 8-bit and wraps modulo 256.
- Reset mid-handshake: irq_req drops asynchronously and all state returns to reset values.

Optional Feature:
- Macro: TC_IRQ_EDGE_DETECT_EN.
- Defined: PEND[i] sets only on a 0->1 transition of src_irq[i], using a prev register that resets to 0. A source held high sets the flag once, so a W1C clear is not immediately re-set.
- Undefined: level-sensitive set as described in Behaviour.

Test Plan:
- Reset, write EN=8'h01 and CTRL=8'h01, pulse src_irq[0] for 1 cycle -> irq_req=1 three edges later, irq_vec=8'h0B, held until ack; after ack PEND reads 8'h00 and CTRL reads 8'h00.
- EN=8'h0F, GIE=1, src_irq=4'b0110 asserted in the same cycle -> irq_vec=8'h0C. After ack and writing GIE=1 -> second request with irq_vec=8'h0D.
- GIE=0, pulse src_irq[2] -> no irq_req; PEND reads 8'h04. Write 8'h04 to ADDR_PEND -> PEND reads 8'h00. Set GIE=1 -> still no irq_req.
- During REQ, write EN=8'h00 -> irq_req stays 1 with the same vector until ack. Pulse irq_ack in IDLE -> no register change.
- Hold src_irq[1]=1 and write 8'h02 to PEND in the same cycle -> PEND[1] reads 1 (set wins). With TC_IRQ_EDGE_DETECT_EN defined and src_irq held high, write 8'h02 -> PEND reads 8'h00.
- Assert rst while irq_req=1 -> irq_req=0 immediately; EN, PEND, CTRL and rdata all read 0.

Source files
------------

// File: rtl/tc_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tc_irq_ctrl
// Brief    : Timer interrupt controller. Pending/enable/GIE registers, fixed
//            priority arbitration and a vectored req/ack CPU handshake.
//            Optional: TC_IRQ_EDGE_DETECT_EN selects rising-edge capture.
// Revision : 1.0
// ============================================================================
module tc_irq_ctrl #(
    parameter int          NSRC      = 4,
    parameter logic [7:0]  VEC_BASE  = 8'h0B,
    parameter logic [7:0]  ADDR_PEND = 8'h3B,
    parameter logic [7:0]  ADDR_EN   = 8'h3D,
    parameter logic [7:0]  ADDR_CTRL = 8'h3F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_irq,
    input  logic [7:0]      addr,
    input  logic [7:0]      wdata,
    input  logic            write,
    input  logic            read,
    output logic [7:0]      rdata,
    output logic            irq_req,
    output logic [7:0]      irq_vec,
    input  logic            irq_ack
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARB  = 2'd1;
    localparam logic [1:0] c_ST_REQ  = 2'd2;

    logic [1:0]      r_state;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_en;
    logic            r_gie;
    logic [2:0]      r_win;

    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_sw_clr;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_act;
    logic [2:0]      w_win;
    logic            w_ack;
    logic            w_wr_pend;
    logic            w_wr_en;
    logic            w_wr_ctrl;
    logic [7:0]      w_pend8;
    logic [7:0]      w_en8;
    logic [7:0]      w_rd_mux;
    logic            w_unused;

    assign w_unused  = ^wdata;
    assign w_wr_pend = write && (addr == ADDR_PEND);
    assign w_wr_en   = write && (addr == ADDR_EN);
    assign w_wr_ctrl = write && (addr == ADDR_CTRL);
    assign w_ack     = (r_state == c_ST_REQ) && irq_ack;
    assign w_act     = r_pend & r_en;
    assign w_sw_clr  = w_wr_pend ? wdata[NSRC-1:0] : '0;

`ifdef TC_IRQ_EDGE_DETECT_EN
    logic [NSRC-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= src_irq;
        end
    end

    assign w_set = src_irq & ~r_prev;
`else
    assign w_set = src_irq;
`endif

    // Lowest active index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_win = 3'(i);
            end
        end
    end

    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ack_clr[i] = w_ack && (r_win == 3'(i));
        end
    end

    always_comb begin
        w_pend8             = '0;
        w_en8               = '0;
        w_pend8[NSRC-1:0]   = r_pend;
        w_en8[NSRC-1:0]     = r_en;
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (addr == ADDR_PEND) begin
            w_rd_mux = w_pend8;
        end else if (addr == ADDR_EN) begin
            w_rd_mux = w_en8;
        end else if (addr == ADDR_CTRL) begin
            w_rd_mux = {7'd0, r_gie};
        end
    end

    // Set is OR-ed in last so it overrides any clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_en   <= '0;
            r_gie  <= 1'b0;
            rdata  <= 8'h00;
        end else begin
            r_pend <= (r_pend & ~(w_sw_clr | w_ack_clr)) | w_set;
            if (w_wr_en) begin
                r_en <= wdata[NSRC-1:0];
            end
            if (w_ack) begin
                r_gie <= 1'b0;
            end else if (w_wr_ctrl) begin
                r_gie <= wdata[0];
            end
            if (read) begin
                rdata <= w_rd_mux;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_win   <= '0;
            irq_req <= 1'b0;
            irq_vec <= 8'h00;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_gie && (w_act != '0)) begin
                        r_win   <= w_win;
                        r_state <= c_ST_ARB;
                    end
                end
                c_ST_ARB: begin
                    irq_vec <= VEC_BASE + {5'd0, r_win};
                    irq_req <= 1'b1;
                    r_state <= c_ST_REQ;
                end
                c_ST_REQ: begin
                    if (irq_ack) begin
                        irq_req <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    irq_req <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_irq_ctrl
// Brief    : Randomized scoreboard bench for tc_irq_ctrl with a rule-level model.
// Revision : 1.0
// ============================================================================
module tb_tc_irq_ctrl;

    localparam int         NSRC = 4;
    localparam int         MASK = (1 << NSRC) - 1;
    localparam logic [7:0] VB   = 8'h0B;
    localparam logic [7:0] AP   = 8'h3B;
    localparam logic [7:0] AE   = 8'h3D;
    localparam logic [7:0] AC   = 8'h3F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] src_irq = '0;
    logic [7:0]      addr = 8'h00;
    logic [7:0]      wdata = 8'h00;
    logic            write = 1'b0;
    logic            read = 1'b0;
    logic            irq_ack = 1'b0;
    logic [7:0]      rdata;
    logic [7:0]      irq_vec;
    logic            irq_req;

    tc_irq_ctrl #(.NSRC(NSRC)) dut (
        .clk(clk), .rst(rst), .src_irq(src_irq), .addr(addr), .wdata(wdata),
        .write(write), .read(read), .rdata(rdata), .irq_req(irq_req),
        .irq_vec(irq_vec), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents as plain integers plus the committed request.
    int  m_pend, m_en, m_gie, m_prev, m_win, m_vec;
    int  m_wait;      // -1 idle, 1 = winner chosen (req next edge), 0 = request outstanding
    bit  m_req;
    logic [7:0] rq[$];
    logic [7:0] vq[$];

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pend = 0; m_en = 0; m_gie = 0; m_prev = 0; m_win = 0; m_vec = 0;
        m_wait = -1; m_req = 0;
        rq.delete();
        vq.delete();
    endfunction

    function automatic int reg_value(logic [7:0] a);
        if (a == AP) return m_pend;
        if (a == AE) return m_en;
        if (a == AC) return m_gie;
        return 0;
    endfunction

    function automatic int lowest(int v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        int  s, d, set, clr, act;
        bit  acked;
        s     = int'(src_irq);
        d     = int'(wdata);
        acked = m_req && irq_ack;
        if (read) rq.push_back(8'(reg_value(addr)));
`ifdef TC_IRQ_EDGE_DETECT_EN
        set = s & ~m_prev & MASK;
`else
        set = s;
`endif
        m_prev = s;
        clr = (write && addr == AP) ? (d & MASK) : 0;
        if (acked) clr = clr | (1 << m_win);
        act = m_pend & m_en;
        if (m_wait == 0) begin
            if (acked) begin
                m_req  = 0;
                m_wait = -1;
            end
        end else if (m_wait == 1) begin
            m_wait = 0;
            m_req  = 1;
            m_vec  = (int'(VB) + m_win) % 256;
            vq.push_back(8'(m_vec));
        end else if (m_gie != 0 && act != 0) begin
            m_win  = lowest(act);
            m_wait = 1;
        end
        m_pend = (m_pend & ~clr) | set;
        if (write && addr == AE) m_en = d & MASK;
        if (acked) m_gie = 0;
        else if (write && addr == AC) m_gie = d & 1;
    endtask

    task automatic tick(input logic [NSRC-1:0] s, input bit wr, input bit rd,
                        input logic [7:0] a, input logic [7:0] d, input bit ack);
        src_irq = s; write = wr; read = rd; addr = a; wdata = d; irq_ack = ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        tick('0, 1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd_reg(input logic [7:0] a);
        tick('0, 1'b0, 1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic ack();
        tick('0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    // Monitor: pops expected read data / request vectors as the DUT presents them.
    logic rd_seen = 1'b0;
    logic prev_req = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_seen <= 1'b0;
        else     rd_seen <= read;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (rd_seen) begin
                if (rq.size() == 0) chk("rdata_unexpected", 8'h01, 8'h00);
                else                chk("rdata", rdata, rq.pop_front());
            end
            if (irq_req && !prev_req) begin
                if (vq.size() == 0) chk("irq_req_unexpected", 8'h01, 8'h00);
                else                chk("irq_vec_rise", irq_vec, vq.pop_front());
            end
            chk("irq_req", {7'd0, irq_req}, {7'd0, m_req});
            chk("irq_vec", irq_vec, 8'(m_vec));
            prev_req = irq_req;
        end
    end

    logic [7:0] addr_tbl [5];

    initial begin
        addr_tbl = '{AP, AE, AC, 8'h3C, 8'h00};
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_irq_req", {7'd0, irq_req}, 8'h00);
        chk("reset_irq_vec", irq_vec, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Single source, three-edge latency, ack clears PEND and GIE.
        wr_reg(AE, 8'h01); wr_reg(AC, 8'h01);
        tick(4'b0001, 0, 0, 8'h00, 8'h00, 0);
        idle(5); ack(); idle(2);
        rd_reg(AP); rd_reg(AC);

        // Simultaneous sources: priority, then re-enable for the next one.
        wr_reg(AE, 8'h0F); wr_reg(AC, 8'h01);
        tick(4'b0110, 0, 0, 8'h00, 8'h00, 0);
        idle(4); ack(); idle(2);
        wr_reg(AC, 8'h01); idle(4); ack(); idle(2);
        rd_reg(AP);

        // GIE off: flag pends without request; W1C then GIE on.
        wr_reg(AC, 8'h00);
        tick(4'b0100, 0, 0, 8'h00, 8'h00, 0);
        idle(3); rd_reg(AP);
        wr_reg(AP, 8'h04); rd_reg(AP);
        wr_reg(AC, 8'h01); idle(4);

        // Commit: clearing EN during REQ keeps the request; stray ack ignored.
        tick(4'b0001, 0, 0, 8'h00, 8'h00, 0);
        idle(4); wr_reg(AE, 8'h00); idle(3); ack(); idle(2);
        ack(); rd_reg(AP); rd_reg(AE); rd_reg(AC);

        // Set wins over W1C; held source with edge mode does not re-set.
        tick(4'b0010, 1, 0, AP, 8'h02, 0);
        tick(4'b0010, 0, 1, AP, 8'h00, 0);
        tick(4'b0010, 1, 0, AP, 8'h02, 0);
        tick(4'b0010, 0, 1, AP, 8'h00, 0);
        tick(4'b0000, 0, 1, AP, 8'h00, 0);
        tick(4'b0000, 1, 1, AP, 8'hFF, 0);
        rd_reg(AP); rd_reg(8'h3C);

        // Reset mid-handshake.
        wr_reg(AE, 8'h01); wr_reg(AC, 8'h01);
        tick(4'b0001, 0, 0, 8'h00, 8'h00, 0);
        idle(5);
        rst = 1'b1;
        #1;
        chk("rst_irq_req", {7'd0, irq_req}, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rd_reg(AE); rd_reg(AP); rd_reg(AC);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [NSRC-1:0] s;
            logic [7:0]      a, d;
            bit              wr, rd, ak;
            s  = ($urandom_range(0, 5) == 0) ? NSRC'($urandom) : '0;
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) == 0);
            a  = addr_tbl[$urandom_range(0, 4)];
            d  = 8'($urandom);
            if (a == AC && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            ak = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            tick(s, wr, rd, a, d, ak);
        end

        for (int n = 0; n < 10 && m_req; n++) ack();
        idle(3);
        chk("vec_queue_empty", 8'(vq.size()), 8'h00);
        chk("rd_queue_empty", 8'(rq.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
